// File: rtl/hs32_pkg.sv
// Shared HS32 register-file definitions: default geometry, bank encodings, sequencer states.
package hs32_pkg;

  localparam int HS32_ADDR_WIDTH = 4;
  localparam int HS32_DATA_WIDTH = 32;
  localparam int HS32_NBANKS     = 2;
  localparam int HS32_NREAD      = 2;

  localparam logic [0:0] BANK_USER = 1'b0;
  localparam logic [0:0] BANK_SUPV = 1'b1;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  // Bank select width; a single-bank file still carries a 1-bit bank field.
  function automatic int bank_width(input int nbanks);
    return (nbanks > 1) ? $clog2(nbanks) : 1;
  endfunction

endpackage

// File: rtl/hs32_regfile_port.sv
// One registered read port of the HS32 register file.
// With HS32_REGFILE_BYPASS_EN defined, a same-cycle write to the addressed entry is forwarded.
module hs32_regfile_port
  import hs32_pkg::*;
#(
  parameter int ADDR_WIDTH = HS32_ADDR_WIDTH,
  parameter int DATA_WIDTH = HS32_DATA_WIDTH,
  parameter int BANK_W     = 1,
  parameter int DEPTH      = 32,
  parameter int IDX_W      = 5
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             run,
  input  logic                             re,
  input  logic [BANK_W-1:0]                bank,
  input  logic [ADDR_WIDTH-1:0]            adr,
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem,
`ifdef HS32_REGFILE_BYPASS_EN
  input  logic                             wr_en,
  input  logic [IDX_W-1:0]                 wr_idx,
  input  logic [DATA_WIDTH-1:0]            din,
`endif
  output logic [DATA_WIDTH-1:0]            dout
);

  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] rdata;

  // Truncation drops the bank bit only when NBANKS==1.
  assign idx = IDX_W'({bank, adr});

`ifdef HS32_REGFILE_BYPASS_EN
  assign rdata = (wr_en && (wr_idx == idx)) ? din : mem[idx];
`else
  assign rdata = mem[idx];
`endif

  always_ff @(posedge clk) begin
    if (reset)
      dout <= '0;
    else if (run && re)
      dout <= rdata;
  end

endmodule

// File: rtl/hs32_regfile.sv
// Banked, multi-read-port HS32 register file with post-reset hardware clear.
// Optional write-first forwarding: define HS32_REGFILE_BYPASS_EN.
module hs32_regfile
  import hs32_pkg::*;
#(
  parameter int ADDR_WIDTH = HS32_ADDR_WIDTH,
  parameter int DATA_WIDTH = HS32_DATA_WIDTH,
  parameter int NBANKS     = HS32_NBANKS,
  parameter int NREAD      = HS32_NREAD,
  parameter int BANK_W     = bank_width(NBANKS)
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         busy,
  input  logic                         we,
  input  logic [BANK_W-1:0]            wbank,
  input  logic [ADDR_WIDTH-1:0]        wadr,
  input  logic [DATA_WIDTH-1:0]        din,
  input  logic                         re,
  input  logic [NREAD*BANK_W-1:0]      rbank,
  input  logic [NREAD*ADDR_WIDTH-1:0]  radr,
  output logic [NREAD*DATA_WIDTH-1:0]  dout
);

  localparam int DEPTH = NBANKS * (2 ** ADDR_WIDTH);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  logic [0:0]                       state;
  logic [IDX_W-1:0]                 cnt;
  logic [IDX_W-1:0]                 widx;
  logic                             run;
  logic                             wr_en;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

  assign run   = (state == ST_RUN);
  assign busy  = ~run;
  assign widx  = IDX_W'({wbank, wadr});
  assign wr_en = run && we;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else if (state == ST_CLEAR) begin
      cnt <= cnt + 1'b1;
      if (cnt == LAST)
        state <= ST_RUN;
    end
  end

  // Storage has no reset; the clear sequencer zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ST_CLEAR)
        mem[cnt] <= '0;
      else if (we)
        mem[widx] <= din;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_port
    hs32_regfile_port #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .BANK_W     (BANK_W),
      .DEPTH      (DEPTH),
      .IDX_W      (IDX_W)
    ) u_port (
      .clk    (clk),
      .reset  (reset),
      .run    (run),
      .re     (re),
      .bank   (rbank[i*BANK_W +: BANK_W]),
      .adr    (radr[i*ADDR_WIDTH +: ADDR_WIDTH]),
      .mem    (mem),
`ifdef HS32_REGFILE_BYPASS_EN
      .wr_en  (wr_en),
      .wr_idx (widx),
      .din    (din),
`endif
      .dout   (dout[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_hs32_regfile.sv
// Randomized self-checking bench for hs32_regfile against a cycle-level behavioural model.
module tb_hs32_regfile;
  import hs32_pkg::*;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int NB = 2;
  localparam int NR = 2;
  localparam int BW = 1;
  localparam int D  = NB * (1 << AW);

  logic              clk = 1'b0;
  logic              reset;
  logic              busy;
  logic              we;
  logic [BW-1:0]     wbank;
  logic [AW-1:0]     wadr;
  logic [DW-1:0]     din;
  logic              re;
  logic [NR*BW-1:0]  rbank;
  logic [NR*AW-1:0]  radr;
  logic [NR*DW-1:0]  dout;

  hs32_regfile #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NBANKS     (NB),
    .NREAD      (NR)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .busy  (busy),
    .we    (we),
    .wbank (wbank),
    .wadr  (wadr),
    .din   (din),
    .re    (re),
    .rbank (rbank),
    .radr  (radr),
    .dout  (dout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: an array of entries, per-port output values, and a clear countdown.
  logic [DW-1:0] m_mem [D];
  logic [DW-1:0] m_dout [NR];
  int            m_left;
  bit            m_busy;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] port_out(input int p);
    return dout[p*DW +: DW];
  endfunction

  // Advance model with the current inputs, clock once, compare everything.
  task automatic step();
    int ridx;
    int widx;
    logic [DW-1:0] v;
    widx = int'(wbank) * (1 << AW) + int'(wadr);
    if (reset) begin
      m_busy = 1'b1;
      m_left = D;
      for (int p = 0; p < NR; p++) m_dout[p] = '0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        for (int e = 0; e < D; e++) m_mem[e] = '0;
      end
    end else begin
      if (re)
        for (int p = 0; p < NR; p++) begin
          ridx = int'(rbank[p*BW +: BW]) * (1 << AW) + int'(radr[p*AW +: AW]);
          v = m_mem[ridx];
`ifdef HS32_REGFILE_BYPASS_EN
          if (we && ridx == widx) v = din;
`endif
          m_dout[p] = v;
        end
      if (we) m_mem[widx] = din;
    end
    @(posedge clk);
    #1;
    chk("busy", 64'(busy), 64'(m_busy));
    for (int p = 0; p < NR; p++)
      chk($sformatf("dout%0d", p), 64'(port_out(p)), 64'(m_dout[p]));
  endtask

  task automatic idle();
    we = 1'b0; re = 1'b0;
  endtask

  task automatic wr(input logic [BW-1:0] b, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = 1'b1; re = 1'b0; wbank = b; wadr = a; din = d;
    step();
    we = 1'b0;
  endtask

  task automatic rd(input logic [BW-1:0] b0, input logic [AW-1:0] a0,
                    input logic [BW-1:0] b1, input logic [AW-1:0] a1);
    we = 1'b0; re = 1'b1; rbank = {b1, b0}; radr = {a1, a0};
    step();
    re = 1'b0;
  endtask

  // Counts busy-high cycles from here until busy falls (bounded).
  task automatic count_clear(output int hi);
    hi = 0;
    for (int c = 0; c < D + 8 && busy; c++) begin
      we = 1'b1; re = 1'b1; wbank = BANK_USER; wadr = 4'd9; din = $urandom;
      rbank = {BANK_SUPV, BANK_USER}; radr = {4'd9, 4'd9};
      step();
      hi++;
    end
    idle();
  endtask

  initial begin
    int hi;
    for (int e = 0; e < D; e++) m_mem[e] = '0;
    m_busy = 1'b1; m_left = D;
    for (int p = 0; p < NR; p++) m_dout[p] = '0;
    reset = 1'b1; we = 1'b0; re = 1'b0; wbank = '0; wadr = '0; din = '0; rbank = '0; radr = '0;

    step();
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_dout", 64'(dout), 64'd0);
    reset = 1'b0;
    count_clear(hi);
    chk("clear_len", 64'(hi), 64'(D));

    for (int e = 0; e < D; e += 2) begin
      rd(BW'(e >> AW), AW'(e), BW'((e + 1) >> AW), AW'(e + 1));
      chk("post_clear", 64'(dout), 64'd0);
    end

    wr(BANK_USER, 4'd3, 32'hDEADBEEF);
    wr(BANK_SUPV, 4'd3, 32'h12345678);
    rd(BANK_USER, 4'd3, BANK_SUPV, 4'd3);
    chk("rd_b0r3", 64'(port_out(0)), 64'h0DEADBEEF);
    chk("rd_b1r3", 64'(port_out(1)), 64'h012345678);

    wr(BANK_USER, 4'd5, 32'h1);
    we = 1'b1; wbank = BANK_USER; wadr = 4'd5; din = 32'hA5A5A5A5;
    re = 1'b1; rbank = {BANK_SUPV, BANK_USER}; radr = {4'd3, 4'd5};
    step();
`ifdef HS32_REGFILE_BYPASS_EN
    chk("same_cyc", 64'(port_out(0)), 64'h0A5A5A5A5);
`else
    chk("same_cyc", 64'(port_out(0)), 64'h000000001);
`endif
    rd(BANK_USER, 4'd5, BANK_USER, 4'd5);
    chk("after_wr", 64'(port_out(0)), 64'h0A5A5A5A5);

    re = 1'b0;
    repeat (4) begin
      radr = NR*AW'($urandom); rbank = NR*BW'($urandom);
      step();
    end
    chk("hold0", 64'(port_out(0)), 64'h0A5A5A5A5);
    chk("hold1", 64'(port_out(1)), 64'h0A5A5A5A5);

    wr(BANK_USER, 4'd7, 32'h55);
    reset = 1'b1; step(); reset = 1'b0;
    repeat (10) step();
    chk("mid_busy", 64'(busy), 64'd1);
    reset = 1'b1; step(); reset = 1'b0;
    count_clear(hi);
    chk("restart_len", 64'(hi), 64'(D));
    rd(BANK_USER, 4'd7, BANK_USER, 4'd9);
    chk("r7_zero", 64'(port_out(0)), 64'd0);
    chk("busy_tgt", 64'(port_out(1)), 64'd0);

    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      we    = $urandom_range(0, 1);
      re    = $urandom_range(0, 2) != 0;
      wbank = BW'($urandom);
      wadr  = AW'($urandom_range(0, 3));
      din   = $urandom;
      rbank = NR*BW'($urandom);
      radr  = {AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3))};
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
